// File: rtl/draw_player.sv
// Player ship overlay stage of the VGA draw chain.
// Composites the player sprite (fetched from an external synchronous ROM) onto
// the incoming background stream at column xpos_lat and a fixed top row YPOS.
// After a hit the ship blinks for a fixed number of frames. All outputs carry a
// fixed two-cycle latency relative to the timing inputs.
module draw_player #(
    parameter int          PLAYER_WIDTH  = 32,
    parameter int          PLAYER_HEIGHT = 16,
    parameter int          YPOS          = 560,
    parameter logic [11:0] TRANSPARENT   = 12'h0F0,
    parameter int          BLINK_FRAMES  = 8,
    parameter int          BLINK_TOGGLES = 6,
    parameter int          HOR_PIXELS    = 800,
    localparam int         COL_W         = $clog2(PLAYER_WIDTH),
    localparam int         ROW_W         = $clog2(PLAYER_HEIGHT),
    localparam int         ADDR_W        = ROW_W + COL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       xpos,
    input  logic              hit,
    input  logic [10:0]       vcount_in,
    input  logic              vsync_in,
    input  logic              vblnk_in,
    input  logic [10:0]       hcount_in,
    input  logic              hsync_in,
    input  logic              hblnk_in,
    input  logic [11:0]       rgb_in,
    output logic [ADDR_W-1:0] pixel_addr,
    input  logic [11:0]       pixel_rgb,
    output logic [10:0]       vcount_out,
    output logic              vsync_out,
    output logic              vblnk_out,
    output logic [10:0]       hcount_out,
    output logic              hsync_out,
    output logic              hblnk_out,
    output logic [11:0]       rgb_out,
    output logic              blinking
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int TC_W = $clog2(BLINK_TOGGLES + 1);

    localparam logic [FC_W-1:0] FRAME_LAST  = FC_W'(BLINK_FRAMES - 1);
    localparam logic [TC_W-1:0] TOGGLE_LAST = TC_W'(BLINK_TOGGLES - 1);

    localparam logic [11:0] Y_TOP   = 12'(YPOS);
    localparam logic [11:0] Y_END   = 12'(YPOS + PLAYER_HEIGHT);
    localparam logic [12:0] W_EXT   = 13'(PLAYER_WIDTH);
    localparam logic [11:0] X_RESET = 12'(HOR_PIXELS / 2);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BLINK = 1'b1;

    // ------------------------------------------------------------------
    // Frame tick: first pixel of a frame. Used both to latch the sprite
    // position (so the ship never tears mid-frame) and to pace blinking.
    // ------------------------------------------------------------------
    logic frame_tick;
    assign frame_tick = (vcount_in == 11'd0) && (hcount_in == 11'd0);

    logic [11:0] xpos_lat;

    // Latch the requested position once per frame.
    always_ff @(posedge clk) begin
        // NOTE: registers are always written with <= so every flop samples
        // the pre-edge values of the others, regardless of statement order.
        if (rst) begin
            xpos_lat <= X_RESET;
        end else if (frame_tick) begin
            xpos_lat <= xpos;
        end
    end

    // ------------------------------------------------------------------
    // Blink sequencer
    // ------------------------------------------------------------------
    logic [0:0]      state;
    logic [FC_W-1:0] frame_cnt;
    logic [TC_W-1:0] toggle_cnt;
    logic            visible;

    // Hit (re)starts the sequence; frame ticks advance it until the last toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            frame_cnt  <= '0;
            toggle_cnt <= '0;
            visible    <= 1'b1;
        end else if (hit) begin
            // A hit coinciding with a frame tick restarts; the tick is dropped.
            state      <= S_BLINK;
            frame_cnt  <= '0;
            toggle_cnt <= '0;
            visible    <= 1'b0;
        end else if (state == S_BLINK && frame_tick) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                if (toggle_cnt == TOGGLE_LAST) begin
                    // Final toggle ends the sequence with the ship shown.
                    state      <= S_IDLE;
                    toggle_cnt <= '0;
                    visible    <= 1'b1;
                end else begin
                    toggle_cnt <= toggle_cnt + 1'b1;
                    visible    <= ~visible;
                end
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign blinking = (state == S_BLINK);

    // ------------------------------------------------------------------
    // Stage 1 decode: is the current pixel inside the sprite box, and
    // which ROM word does it need.
    // ------------------------------------------------------------------
    logic [12:0]       h_ext;
    logic [12:0]       x_start;
    logic [12:0]       x_end;
    logic [11:0]       v_ext;
    logic [COL_W-1:0]  col_off;
    logic [ROW_W-1:0]  row_off;
    logic              in_sprite;
    logic [ADDR_W-1:0] addr_next;

    // Widen before comparing so xpos_lat + width can never wrap.
    assign h_ext   = {2'b00, hcount_in};
    assign x_start = {1'b0, xpos_lat};
    assign x_end   = x_start + W_EXT;
    assign v_ext   = {1'b0, vcount_in};
    assign col_off = COL_W'(hcount_in) - COL_W'(xpos_lat);
    assign row_off = ROW_W'(vcount_in) - ROW_W'(Y_TOP);

    // Sprite window test and ROM address generation.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        in_sprite = 1'b0;
        addr_next = '0;
        if (!hblnk_in && !vblnk_in &&
            h_ext >= x_start && h_ext < x_end &&
            v_ext >= Y_TOP   && v_ext < Y_END) begin
            in_sprite = 1'b1;
            addr_next = {row_off, col_off};
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [10:0] vcount_d1;
    logic        vsync_d1;
    logic        vblnk_d1;
    logic [10:0] hcount_d1;
    logic        hsync_d1;
    logic        hblnk_d1;
    logic [11:0] rgb_d1;
    logic        in_sprite_d1;
    logic        visible_d1;

    // Register timing, background and the sprite decision; drive the ROM.
    always_ff @(posedge clk) begin
        if (rst) begin
            vcount_d1    <= '0;
            vsync_d1     <= 1'b0;
            vblnk_d1     <= 1'b0;
            hcount_d1    <= '0;
            hsync_d1     <= 1'b0;
            hblnk_d1     <= 1'b0;
            rgb_d1       <= '0;
            in_sprite_d1 <= 1'b0;
            visible_d1   <= 1'b0;
            pixel_addr   <= '0;
        end else begin
            vcount_d1    <= vcount_in;
            vsync_d1     <= vsync_in;
            vblnk_d1     <= vblnk_in;
            hcount_d1    <= hcount_in;
            hsync_d1     <= hsync_in;
            hblnk_d1     <= hblnk_in;
            rgb_d1       <= rgb_in;
            in_sprite_d1 <= in_sprite;
            // Visibility is frozen per pixel here, alongside the window test.
            visible_d1   <= visible;
            pixel_addr   <= addr_next;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers. The ROM captures pixel_addr on this same edge, so
    // its data is valid during the stage-2 cycle and the final colour mux
    // is combinational on these registers and pixel_rgb.
    // ------------------------------------------------------------------
    logic [11:0] rgb_d2;
    logic        in_sprite_d2;
    logic        visible_d2;

    // Second pipeline stage: timing outputs and the compositing controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            vcount_out   <= '0;
            vsync_out    <= 1'b0;
            vblnk_out    <= 1'b0;
            hcount_out   <= '0;
            hsync_out    <= 1'b0;
            hblnk_out    <= 1'b0;
            rgb_d2       <= '0;
            in_sprite_d2 <= 1'b0;
            visible_d2   <= 1'b0;
        end else begin
            vcount_out   <= vcount_d1;
            vsync_out    <= vsync_d1;
            vblnk_out    <= vblnk_d1;
            hcount_out   <= hcount_d1;
            hsync_out    <= hsync_d1;
            hblnk_out    <= hblnk_d1;
            rgb_d2       <= rgb_d1;
            in_sprite_d2 <= in_sprite_d1;
            visible_d2   <= visible_d1;
        end
    end

    // Composite: opaque, visible sprite pixels replace the background.
    always_comb begin
        rgb_out = rgb_d2;
        if (in_sprite_d2 && visible_d2 && pixel_rgb != TRANSPARENT) begin
            rgb_out = pixel_rgb;
        end
    end

endmodule

// File: tb/tb_draw_player.sv
// Self-checking bench for draw_player: constant vector table, directed
// multi-cycle sequences and randomized traffic against a frame-level model.
module tb_draw_player;

    localparam int W    = 32;
    localparam int H    = 16;
    localparam int YP   = 560;
    localparam int HP   = 800;
    localparam int HALF = 8;    // frames per blink half-period
    localparam int SEQ  = 48;   // frames in a full blink sequence

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] xpos;
    logic        hit;
    logic [10:0] vcount_in, hcount_in;
    logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
    logic [11:0] rgb_in;
    logic [8:0]  pixel_addr;
    logic [11:0] pixel_rgb;
    logic [10:0] vcount_out, hcount_out;
    logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
    logic [11:0] rgb_out;
    logic        blinking;

    always #5 clk = ~clk;

    draw_player dut (
        .clk(clk), .rst(rst), .xpos(xpos), .hit(hit),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in), .pixel_addr(pixel_addr), .pixel_rgb(pixel_rgb),
        .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .rgb_out(rgb_out), .blinking(blinking)
    );

    // Synchronous sprite ROM: data follows the address by one clock.
    logic [11:0] rom [512];
    always @(posedge clk) pixel_rgb <= rom[pixel_addr];

    // ------------------------------------------------------------------
    // Reference model: per-frame position, blink progress in frames.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [11:0] rgb;
        logic [8:0]  addr;
        logic [10:0] h;
        logic [10:0] v;
        logic        hs, vs, hb, vb;
    } exp_t;

    int   m_xlat   = HP / 2;
    bit   m_active = 1'b0;   // blink sequence running
    int   m_k      = 0;      // frame ticks counted since the last hit
    exp_t e_cur, e_prev;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t predict(input int h, input int v, input bit hb, input bit vb,
                                     input bit hs, input bit vs, input logic [11:0] rgb);
        exp_t e;
        bit   in_spr, vis;
        int   a;
        in_spr = !hb && !vb && h >= m_xlat && h < m_xlat + W && v >= YP && v < YP + H;
        a      = in_spr ? (v - YP) * W + (h - m_xlat) : 0;
        vis    = !m_active || ((m_k / HALF) % 2 == 1);
        e.rgb  = (in_spr && vis && rom[a] != 12'h0F0) ? rom[a] : rgb;
        e.addr = 9'(a);
        e.h    = 11'(h);
        e.v    = 11'(v);
        e.hs   = hs;
        e.vs   = vs;
        e.hb   = hb;
        e.vb   = vb;
        return e;
    endfunction

    // One pixel clock: drive, predict, clock, advance the model, compare.
    task automatic cycle(input int h, input int v, input bit hb, input bit vb,
                         input logic [11:0] rgb, input bit hit_i, input bit rst_i);
        bit hs, vs, tick;
        hs        = 1'($urandom_range(0, 1));
        vs        = 1'($urandom_range(0, 1));
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = hb;
        vblnk_in  = vb;
        hsync_in  = hs;
        vsync_in  = vs;
        rgb_in    = rgb;
        hit       = hit_i;
        rst       = rst_i;
        e_cur     = predict(h, v, hb, vb, hs, vs, rgb);
        @(posedge clk);
        #1;
        if (rst_i) begin
            m_xlat   = HP / 2;
            m_active = 1'b0;
            m_k      = 0;
            e_cur    = '0;
            e_prev   = '0;
        end else begin
            tick = (h == 0 && v == 0);
            if (tick) m_xlat = int'(xpos);
            if (hit_i) begin
                m_active = 1'b1;
                m_k      = 0;
            end else if (tick && m_active) begin
                m_k++;
                if (m_k == SEQ) m_active = 1'b0;
            end
        end
        check("pixel_addr", 32'(pixel_addr), 32'(e_cur.addr));
        check("rgb_out", 32'(rgb_out), 32'(e_prev.rgb));
        check("timing_out",
              32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
              32'({e_prev.h, e_prev.v, e_prev.hs, e_prev.vs, e_prev.hb, e_prev.vb}));
        check("blinking", 32'(blinking), 32'(m_active));
        e_prev = e_cur;
        hit    = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic idle();
        cycle(5, 5, 1'b0, 1'b0, 12'($urandom_range(0, 4095)), 1'b0, 1'b0);
    endtask

    task automatic frame_tick(input logic [11:0] new_x);
        xpos = new_x;
        cycle(0, 0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    endtask

    // Apply one pixel, flush it through the pipeline, check its colour.
    task automatic pix(input string name, input int h, input int v, input logic [11:0] rgb,
                       input logic [11:0] exp_rgb);
        cycle(h, v, 1'b0, 1'b0, rgb, 1'b0, 1'b0);
        idle();
        check(name, 32'(rgb_out), 32'(exp_rgb));
    endtask

    typedef struct {
        int          h, v;
        bit          hb, vb;
        logic [11:0] rgb;
        logic [8:0]  exp_addr;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // Pattern ROM: word a holds 12'hA00 | a, with two special words.
        for (int a = 0; a < 512; a++) rom[a] = 12'hA00 | 12'(a);
        rom[0] = 12'hFFF;
        rom[1] = 12'h0F0;

        // Sprite at reset position 400: columns 400..431, rows 560..575.
        tbl[0]  = '{400, 560, 1'b0, 1'b0, 12'h123, 9'd0,   12'hFFF};
        tbl[1]  = '{401, 560, 1'b0, 1'b0, 12'h456, 9'd1,   12'h456};
        tbl[2]  = '{402, 561, 1'b0, 1'b0, 12'h111, 9'd34,  12'hA22};
        tbl[3]  = '{431, 575, 1'b0, 1'b0, 12'h222, 9'd511, 12'hBFF};
        tbl[4]  = '{432, 560, 1'b0, 1'b0, 12'h777, 9'd0,   12'h777};
        tbl[5]  = '{399, 560, 1'b0, 1'b0, 12'h888, 9'd0,   12'h888};
        tbl[6]  = '{400, 559, 1'b0, 1'b0, 12'h999, 9'd0,   12'h999};
        tbl[7]  = '{400, 576, 1'b0, 1'b0, 12'hABC, 9'd0,   12'hABC};
        tbl[8]  = '{410, 565, 1'b1, 1'b0, 12'h321, 9'd0,   12'h321};
        tbl[9]  = '{410, 565, 1'b0, 1'b1, 12'h654, 9'd0,   12'h654};
        tbl[10] = '{410, 565, 1'b0, 1'b0, 12'h000, 9'd170, 12'hAAA};

        xpos = 12'd400;
        hit  = 1'b0;
        rst  = 1'b1;
        e_cur  = '0;
        e_prev = '0;

        // Reset state.
        cycle(5, 5, 1'b0, 1'b0, 12'h5A5, 1'b0, 1'b1);
        cycle(5, 5, 1'b0, 1'b0, 12'h5A5, 1'b0, 1'b1);
        check("reset_rgb_out", 32'(rgb_out), 32'h0);
        check("reset_addr", 32'(pixel_addr), 32'h0);
        check("reset_blinking", 32'(blinking), 32'h0);
        idle();
        idle();

        // Vector table.
        foreach (tbl[i]) begin
            cycle(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb, tbl[i].rgb, 1'b0, 1'b0);
            check($sformatf("tbl%0d_addr", i), 32'(pixel_addr), 32'(tbl[i].exp_addr));
            idle();
            check($sformatf("tbl%0d_rgb", i), 32'(rgb_out), 32'(tbl[i].exp_rgb));
        end

        // Position only changes on the frame tick.
        xpos = 12'd100;
        pix("xpos_not_yet", 100, 560, 12'h135, 12'h135);
        frame_tick(12'd100);
        pix("xpos_100", 100, 560, 12'h123, 12'hFFF);
        xpos = 12'd200;
        cycle(50, 300, 1'b0, 1'b0, 12'h010, 1'b0, 1'b0);
        pix("midframe_old_gone", 200, 560, 12'h321, 12'h321);
        pix("midframe_old_pos", 100, 561, 12'h321, 12'hA20);
        frame_tick(12'd200);
        pix("next_frame_200", 200, 560, 12'h444, 12'hFFF);

        // Right screen edge and blanking beyond it.
        frame_tick(12'(HP - W));
        cycle(HP - 1, 560, 1'b0, 1'b0, 12'h246, 1'b0, 1'b0);
        check("right_col_addr", 32'(pixel_addr), 32'd31);
        idle();
        check("right_col_rgb", 32'(rgb_out), 32'hA1F);
        cycle(HP, 560, 1'b1, 1'b0, 12'h357, 1'b0, 1'b0);
        idle();
        check("hblank_clean", 32'(rgb_out), 32'h357);

        // Left screen edge.
        frame_tick(12'd0);
        cycle(0, 560, 1'b0, 1'b0, 12'h468, 1'b0, 1'b0);
        check("left_col_addr", 32'(pixel_addr), 32'd0);
        idle();
        check("left_col_rgb", 32'(rgb_out), 32'hFFF);
        pix("left_transparent", 1, 560, 12'h579, 12'h579);

        // Reset inside the sprite, with a blink sequence pending.
        frame_tick(12'd100);
        for (int h = 105; h < 109; h++) cycle(h, 565, 1'b0, 1'b0, 12'h0C3, 1'b0, 1'b0);
        cycle(109, 565, 1'b0, 1'b0, 12'h0C3, 1'b1, 1'b0);
        check("hit_sets_blinking", 32'(blinking), 32'h1);
        cycle(110, 565, 1'b0, 1'b0, 12'h0C3, 1'b0, 1'b1);
        check("rst_rgb_zero", 32'(rgb_out), 32'h0);
        check("rst_blink_clear", 32'(blinking), 32'h0);
        cycle(111, 565, 1'b0, 1'b0, 12'h0C3, 1'b0, 1'b0);
        check("rst_rgb_zero_2", 32'(rgb_out), 32'h0);
        pix("rst_xpos_half", 400, 560, 12'h0C3, 12'hFFF);

        // Blink sequence, restarted by a second hit at frame 20.
        frame_tick(12'd300);
        cycle(5, 5, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        check("blink_start", 32'(blinking), 32'h1);
        for (int f = 1; f <= 20; f++) begin
            frame_tick(12'd300);
            cycle(305, 565, 1'b0, 1'b0, 12'h0D1, 1'b0, 1'b0);
        end
        cycle(5, 5, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        for (int g = 1; g <= 50; g++) begin
            frame_tick(12'd300);
            if (g == 1)      pix("blink_hidden_1", 305, 565, 12'h0D1, 12'h0D1);
            else if (g == 8) pix("blink_shown_8", 305, 565, 12'h0D1, 12'hAA5);
            else             cycle(305, 565, 1'b0, 1'b0, 12'h0D1, 1'b0, 1'b0);
            if (g == SEQ - 1) check("blink_still_on", 32'(blinking), 32'h1);
            if (g == SEQ)     check("blink_done", 32'(blinking), 32'h0);
        end
        pix("visible_after_blink", 305, 565, 12'h0D1, 12'hAA5);

        // Randomized traffic against the model.
        idle();
        idle();
        for (int a = 0; a < 512; a++) begin
            rom[a] = ($urandom_range(0, 3) == 0) ? 12'h0F0 : 12'($urandom_range(0, 4095));
        end
        for (int i = 0; i < 4000; i++) begin
            int r, h, v;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 49) == 0) xpos = 12'($urandom_range(0, HP - W));
            if (r < 3) begin
                cycle(0, 0, 1'b0, 1'b0, 12'($urandom_range(0, 4095)),
                      $urandom_range(0, 9) == 0, 1'b0);
            end else begin
                h = m_xlat - 4 + $urandom_range(0, 40);
                if (h < 1) h = 1;
                v = 556 + $urandom_range(0, 23);
                cycle(h, v, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                      12'($urandom_range(0, 4095)), $urandom_range(0, 799) == 0,
                      $urandom_range(0, 1999) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
